// File: rtl/axi_tile_loader_pkg.sv
// Shared types and constants for the controller-to-loader request path.
// Holds the buffer geometry, buffer base addresses, request/response
// structs and the loader FSM state encoding.
package axi_tile_loader_pkg;

    // On-chip buffer sizes in bits and their depth in 32-bit words.
    localparam int SRAMA       = 4096;
    localparam int SRAMB       = 8192;
    localparam int SRAMC       = 8192;
    localparam int SRAMA_WORDS = SRAMA / 32;
    localparam int SRAMB_WORDS = SRAMB / 32;
    localparam int SRAMC_WORDS = SRAMC / 32;

    // External-memory base address of each source matrix.
    localparam logic [31:0] A_BASE = 32'h0000_1000;
    localparam logic [31:0] B_BASE = 32'h0000_2000;
    localparam logic [31:0] C_BASE = 32'h0000_3000;

    // AXI read response code for a successful transfer.
    localparam logic [1:0] OKAY = 2'b00;

    // Matrix / buffer select, one-hot except D which has no buffer here.
    typedef enum logic [2:0] {
        MAT_D = 3'b000,
        MAT_C = 3'b001,
        MAT_B = 3'b010,
        MAT_A = 3'b100
    } mat_t;

    // Request from the controller.
    typedef struct packed {
        logic        request_valid;
        mat_t        sel;
        logic [7:0]  burst_num;
        logic [7:0]  burst_size;
        logic [15:0] recvbits;
    } AXI_out_t;

    // Response to the controller.
    typedef struct packed {
        logic finish;
    } AXI_in_t;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_ADDR = 2'd1,
        LDR_DATA = 2'd2,
        LDR_DONE = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/axi_tile_loader_ldr_addr_gen.sv
// Burst address generator, global word counter and SRAM write gating.
// Latency: write port is registered, beat at v appears on the SRAM port at v+1.
// Backpressure: none of its own; it only advances on beats the top accepts.
module ldr_addr_gen
    import axi_tile_loader_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         sel_i,
    input  logic [15:0]        recvbits_i,
    input  logic [7:0]         burst_size_i,
    input  logic               burst_end_i,
    input  logic               beat_i,
    input  logic [31:0]        rdata_i,
    output logic [ADDR_W-1:0]  araddr_o,
    output logic               sram_we_o,
    output logic [2:0]         sram_sel_o,
    output logic [WORD_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    output logic               cap_err_o
);

    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [WORD_AW-1:0] w_q, w_d;
    logic [11:0]        need_q, need_d;
    logic [WORD_AW:0]   cap_q, cap_d;
    logic [2:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic [WORD_AW-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [16:0]        need_sum;
    logic               in_need;
    logic               in_cap;

    // Words worth keeping: ceil(recvbits/32).
    assign need_sum = {1'b0, recvbits_i} + 17'd31;
    assign in_need  = (32'(w_q) < 32'(need_q));
    assign in_cap   = ({1'b0, w_q} < cap_q);

    // Next-state: load on request accept, advance address per burst and word per beat.
    always_comb begin
        araddr_d  = araddr_q;
        w_d       = w_q;
        need_d    = need_q;
        cap_d     = cap_q;
        sel_d     = sel_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cap_err_o = 1'b0;
        if (start_i) begin
            w_d    = '0;
            need_d = need_sum[16:5];
            sel_d  = sel_i;
            unique case (sel_i)
                3'b100:  begin araddr_d = ADDR_W'(A_BASE); cap_d = (WORD_AW+1)'(SRAMA_WORDS); end
                3'b010:  begin araddr_d = ADDR_W'(B_BASE); cap_d = (WORD_AW+1)'(SRAMB_WORDS); end
                3'b001:  begin araddr_d = ADDR_W'(C_BASE); cap_d = (WORD_AW+1)'(SRAMC_WORDS); end
                default: begin araddr_d = '0;              cap_d = '0;                        end
            endcase
        end else begin
            if (beat_i) begin
                // Beats past recvbits are silently dropped; a wanted beat that
                // does not fit the buffer is dropped and flagged.
                we_d      = in_need && in_cap;
                cap_err_o = in_need && !in_cap;
                addr_d    = w_q;
                wdata_d   = rdata_i;
                w_d       = w_q + 1'b1;
            end
            if (burst_end_i) begin
                araddr_d = araddr_q + ADDR_W'({burst_size_i, 2'b00});
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_q <= '0;
            w_q      <= '0;
            need_q   <= '0;
            cap_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            araddr_q <= araddr_d;
            w_q      <= w_d;
            need_q   <= need_d;
            cap_q    <= cap_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign araddr_o     = araddr_q;
    assign sram_we_o    = we_q;
    assign sram_sel_o   = sel_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule

// File: rtl/axi_tile_loader.sv
// Loads A/B/C tiles from AXI memory into on-chip buffers via INCR read bursts.
// Latency: arvalid one cycle after request; SRAM write and finish one cycle after final beat.
// Backpressure: AR held until arready; rready is high throughout DATA, stalls follow rvalid.
module axi_tile_loader
    import axi_tile_loader_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_AW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$bits(AXI_out_t)-1:0]   req_i,
    output logic [$bits(AXI_in_t)-1:0]    rsp_o,
    output logic                          req_err_o,
    output logic [ADDR_W-1:0]             araddr_o,
    output logic [7:0]                    arlen_o,
    output logic [2:0]                    arsize_o,
    output logic [1:0]                    arburst_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    input  logic [31:0]                   rdata_i,
    input  logic [1:0]                    rresp_i,
    input  logic                          rlast_i,
    input  logic                          rvalid_i,
    output logic                          rready_o,
    output logic                          sram_we_o,
    output logic [2:0]                    sram_sel_o,
    output logic [WORD_AW-1:0]            sram_addr_o,
    output logic [31:0]                   sram_wdata_o
);

    AXI_out_t   req;
    AXI_in_t    rsp;
    ldr_state_t state_q, state_d;

    logic [7:0] burst_num_q, burst_num_d;
    logic [7:0] burst_size_q, burst_size_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] arlen_q, arlen_d;
    logic       err_q, err_d;

    logic accept;
    logic req_ok;
    logic beat;
    logic beat_last;
    logic last_burst;
    logic cap_err;

    assign req        = req_i;
    assign accept     = (state_q == LDR_IDLE) && req.request_valid;
    assign req_ok     = (req.sel inside {MAT_A, MAT_B, MAT_C}) &&
                        (req.burst_num != 8'd0) && (req.burst_size != 8'd0);
    assign beat       = (state_q == LDR_DATA) && rvalid_i;
    // The local beat count, not rlast, decides where a burst ends.
    assign beat_last  = beat && ((9'(cnt_q) + 9'd1) == {1'b0, burst_size_q});
    assign last_burst = ((idx_q + 8'd1) == burst_num_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LDR_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LDR_IDLE: if (req.request_valid) state_d = req_ok ? LDR_ADDR : LDR_DONE;
            LDR_ADDR: if (arready_i)         state_d = LDR_DATA;
            LDR_DATA: if (beat_last)         state_d = last_burst ? LDR_DONE : LDR_ADDR;
            LDR_DONE:                        state_d = LDR_IDLE;
            default:                         state_d = LDR_IDLE;
        endcase
    end

    // Request latch, burst/beat counters and sticky error.
    always_comb begin
        burst_num_d  = burst_num_q;
        burst_size_d = burst_size_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        arlen_d      = arlen_q;
        err_d        = err_q;
        if (accept) begin
            burst_num_d  = req.burst_num;
            burst_size_d = req.burst_size;
            idx_d        = '0;
            cnt_d        = '0;
            arlen_d      = req_ok ? (req.burst_size - 8'd1) : 8'd0;
            err_d        = !req_ok;
        end else if (beat) begin
            cnt_d = beat_last ? 8'd0 : (cnt_q + 8'd1);
            if (beat_last) idx_d = idx_q + 8'd1;
            if (rlast_i != beat_last) err_d = 1'b1;
            if (rresp_i != OKAY)      err_d = 1'b1;
            if (cap_err)              err_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_num_q  <= '0;
            burst_size_q <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            arlen_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            burst_num_q  <= burst_num_d;
            burst_size_q <= burst_size_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            arlen_q      <= arlen_d;
            err_q        <= err_d;
        end
    end

    ldr_addr_gen #(
        .ADDR_W  (ADDR_W),
        .WORD_AW (WORD_AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .start_i      (accept),
        .sel_i        (req.sel),
        .recvbits_i   (req.recvbits),
        .burst_size_i (burst_size_q),
        .burst_end_i  (beat_last),
        .beat_i       (beat),
        .rdata_i      (rdata_i),
        .araddr_o     (araddr_o),
        .sram_we_o    (sram_we_o),
        .sram_sel_o   (sram_sel_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .cap_err_o    (cap_err)
    );

    assign rsp.finish = (state_q == LDR_DONE);
    assign rsp_o      = rsp;
    assign req_err_o  = err_q;
    assign arlen_o    = arlen_q;
    assign arsize_o   = 3'b010;
    assign arburst_o  = 2'b01;
    assign arvalid_o  = (state_q == LDR_ADDR);
    assign rready_o   = (state_q == LDR_DATA);

endmodule

// File: doc/axi_tile_loader.md
# axi_tile_loader

Responder end of the controller's AXI request interface. It accepts an `AXI_out_t` request and issues AXI4 INCR read bursts on a 32-bit data bus. Returned beats are written into the selected on-chip buffer (SRAM A, B or C), and completion is reported through `AXI_in_t.finish`. Write-back of D is out of scope and is handled by a separate writer.

## Interface
- `ADDR_W`, default 32: AXI address width.
- `WORD_AW`, default 8: SRAM word-address width (256 words, the capacity of a double-buffered B/C buffer).
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_i`, in, `$bits(AXI_out_t)`: request from the controller; `request_valid` is level-sampled.
- `rsp_o`, out, `$bits(AXI_in_t)`: `finish` is a one-cycle pulse.
- `req_err_o`, out, 1: sticky error for the current/last request; cleared when the next request is accepted.
- `araddr_o`, out, `ADDR_W`: burst start address.
- `arlen_o`, out, 8: `burst_size-1`.
- `arsize_o`, out, 3: constant `3'b010`.
- `arburst_o`, out, 2: constant `2'b01` (INCR).
- `arvalid_o`, out, 1 / `arready_i`, in, 1: AR handshake.
- `rdata_i`, in, 32: read data.
- `rresp_i`, in, 2: read response.
- `rlast_i`, in, 1: last-beat marker.
- `rvalid_i`, in, 1 / `rready_o`, out, 1: R handshake.
- `sram_we_o`, out, 1: buffer write enable.
- `sram_sel_o`, out, 3: one-hot, `100`=A, `010`=B, `001`=C.
- `sram_addr_o`, out, `WORD_AW`: word address.
- `sram_wdata_o`, out, 32: write data.

## Operation
- States: `IDLE`, `ADDR`, `DATA`, `DONE`.
- IDLE:
  - On `request_valid=1`, latch `sel`, `burst_num`, `burst_size` and `recvbits`, clear `req_err_o`, and clear the beat and burst counters.
  - Base address: A→`A_BASE`, B→`B_BASE`, C→`C_BASE`.
- Rejected requests go directly to DONE with `req_err_o=1` and no bus traffic. A request is rejected when:
  - `sel` is not exactly one-hot among `100`/`010`/`001` (this includes `000`=D);
  - `burst_num=0`; or
  - `burst_size=0`.
  - Otherwise the FSM moves to ADDR.
- ADDR:
  - `araddr = base + burst_idx*burst_size*4`, computed modulo 2^`ADDR_W`.
  - Hold `arvalid_o` and keep AR fields stable until `arready_i`, then move to DATA.
  - Only one burst is outstanding at a time.
- DATA:
  - `rready_o=1` continuously.
  - Each accepted beat increments a global word counter `w`, which wraps modulo 2^`WORD_AW`.
  - The burst ends on the beat whose in-burst count equals `burst_size`.
  - If `rlast_i` disagrees with the count on any beat, set `req_err_o`; the count is authoritative.
  - At burst end: increment `burst_idx`; if `burst_idx==burst_num` go to DONE, else go to ADDR.
- Write gating for each beat:
  - Write only if `w < ceil(recvbits/32)`; later beats are accepted and discarded.
  - Write only if `w` is within buffer capacity (A: 128 words, B/C: 256 words).
  - A beat beyond capacity is suppressed and sets `req_err_o`.
  - `rresp_i != 2'b00` sets `req_err_o`, but the data is still written.
- DONE: pulse `finish` for one cycle, then go to IDLE.
- The controller must drop `request_valid` in the cycle after `finish`. A level still high in IDLE starts a new request.

## Timing
- Reset values:
  - FSM in IDLE.
  - `arvalid_o`, `rready_o`, `sram_we_o`, `finish` and `req_err_o` all 0.
  - `araddr_o`, `arlen_o`, `sram_addr_o`, `sram_wdata_o` and `sram_sel_o` all 0.
- Reset mid-operation aborts immediately and drops all valids; any outstanding beats are system-reset as well.
- Request sampled in IDLE at cycle t: `arvalid_o` high at t+1.
- The AR handshake at cycle u puts the FSM in DATA at u+1. Beats can be accepted from u+1.
- SRAM write is registered: a beat accepted at cycle v produces `sram_we_o`/`sram_addr_o`/`sram_wdata_o` at v+1.
- `finish` is asserted at v+1 of the final beat, in the same cycle as the final write.
- Between bursts, the next `arvalid_o` goes high in the cycle after the last beat.
- Rejected request: `finish` at t+1.

## Structure
- Add to the shared params package:
  - `localparam` buffer depths in words: `SRAMA/32`, `SRAMB/32`, `SRAMC/32`.
  - `typedef enum` `ldr_state_t`.
  - `localparam` AXI `OKAY`=`2'b00`.
- Reuse `AXI_out_t`, `AXI_in_t` and `mat_t` from the package.
- One sub-module, `ldr_addr_gen`, handles burst address, word counter and capacity/`recvbits` gating.

## Test plan
- A, `A_BASE`=0x1000, `burst_num`=2, `burst_size`=16, `recvbits`=1024, `arready` and `rvalid` always 1:
  - AR at 0x1000 then 0x1040, `arlen`=15.
  - Words 0..31 written to A; `finish` one cycle after the last write's beat.
  - `req_err_o`=0.
- B, `burst_num`=1, `burst_size`=8, `recvbits`=160 → all 8 beats accepted, only words 0..4 written.
- `sel`=000 → no `arvalid`, `finish` at t+1, `req_err_o`=1.
- A, `burst_num`=9, `burst_size`=16 → words 128..143 suppressed, `req_err_o`=1, `finish` after beat 144.
- C, `burst_size`=4, with `rlast` on beat 3 and `rresp`=2 on beat 2 → all 4 words written, `req_err_o`=1.
- Random `arready`/`rvalid` stalls, plus `rst` asserted during DATA → all outputs 0 the next cycle; a fresh request then completes correctly.
